// File: rtl/kyber_pkg.sv
// Shared Kyber constants and the polyvec unpack FSM state encoding.
package kyber_pkg;

    localparam int unsigned KYBER_Q         = 3329;
    localparam int unsigned KYBER_POLYBYTES = 384;
    localparam int unsigned COEF_BITS       = 12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } unpack_state_e;

endpackage

// File: rtl/kyber_coef_pair_decode.sv
// Decodes three packed bytes into two 12-bit Kyber coefficients.
module kyber_coef_pair_decode
    import kyber_pkg::*;
(
    input  logic [23:0]          i_bytes,
    output logic [COEF_BITS-1:0] o_coef0,
    output logic [COEF_BITS-1:0] o_coef1
);

    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;

    assign b0 = i_bytes[7:0];
    assign b1 = i_bytes[15:8];
    assign b2 = i_bytes[23:16];

    assign o_coef0 = {b1[3:0], b0};
    assign o_coef1 = {b2, b1[7:4]};

endmodule

// File: rtl/kyber_polyvec_unpack.sv
// Streams a byte-packed Kyber polyvec out as BRAM words of zero-extended coefficients.
// Optional coefficient range flag enabled by defining KYBER_UNPACK_RANGE_CHECK_EN.
module kyber_polyvec_unpack
    import kyber_pkg::*;
#(
    parameter int unsigned KYBER_K       = 2,
    parameter int unsigned KYBER_N       = 256,
    parameter int unsigned COEF_PER_WORD = 8,
    parameter int unsigned SEED_BYTES    = 32,
    parameter int unsigned IN_W          = 8 * (KYBER_POLYBYTES * KYBER_K + SEED_BYTES),
    localparam int unsigned WORDS        = KYBER_K * KYBER_N / COEF_PER_WORD,
    localparam int unsigned ADDR_W       = $clog2(WORDS),
    localparam int unsigned DATA_W       = 16 * COEF_PER_WORD
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode,
    input  logic [IN_W-1:0]   i_packed,
    output logic              o_valid,
    input  logic              o_ready,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_data,
    output logic              o_last,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_range_err
);

    localparam int unsigned PAIRS     = COEF_PER_WORD / 2;
    localparam int unsigned SEL_W     = COEF_BITS * COEF_PER_WORD;
    localparam int unsigned OFF_W     = $clog2(IN_W) + 1;
    localparam int unsigned SEED_BASE = 8 * SEED_BYTES;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);

    unpack_state_e      state_q, state_d;
    logic               mode_q, mode_d;
    logic               valid_q, valid_d;
    logic               last_q, last_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  data_q, data_d;

    logic               load;
    logic [ADDR_W-1:0]  load_idx;
    logic [OFF_W-1:0]   load_base;
    logic [OFF_W-1:0]   sel_off;
    logic [SEL_W-1:0]   chunk;
    logic [DATA_W-1:0]  word_c;
    logic [COEF_BITS-1:0] coef0 [PAIRS];
    logic [COEF_BITS-1:0] coef1 [PAIRS];

    // Word to fetch next: word 0 of a fresh job in IDLE, otherwise the successor.
    always_comb begin
        load_idx  = addr_q + ADDR_W'(1);
        load_base = mode_q ? '0 : OFF_W'(SEED_BASE);
        if (state_q == ST_IDLE) begin
            load_idx  = '0;
            load_base = mode ? '0 : OFF_W'(SEED_BASE);
        end
        sel_off = load_base + OFF_W'(load_idx) * OFF_W'(SEL_W);
    end

    assign chunk = i_packed[sel_off +: SEL_W];

    for (genvar p = 0; p < PAIRS; p++) begin : g_pair
        kyber_coef_pair_decode u_dec (
            .i_bytes (chunk[24*p +: 24]),
            .o_coef0 (coef0[p]),
            .o_coef1 (coef1[p])
        );
    end

    always_comb begin
        word_c = '0;
        for (int p = 0; p < PAIRS; p++) begin
            word_c[32*p      +: 16] = {4'b0, coef0[p]};
            word_c[32*p + 16 +: 16] = {4'b0, coef1[p]};
        end
    end

`ifdef KYBER_UNPACK_RANGE_CHECK_EN
    logic err_q, err_d;
    logic word_oor_c;

    always_comb begin
        word_oor_c = 1'b0;
        for (int l = 0; l < COEF_PER_WORD; l++) begin
            if (data_q[16*l +: COEF_BITS] >= COEF_BITS'(KYBER_Q)) begin
                word_oor_c = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        valid_d = valid_q;
        last_d  = last_q;
        done_d  = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        load    = 1'b0;
`ifdef KYBER_UNPACK_RANGE_CHECK_EN
        err_d   = err_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    mode_d  = mode;
                    load    = 1'b1;
`ifdef KYBER_UNPACK_RANGE_CHECK_EN
                    err_d   = 1'b0;
`endif
                end
            end
            ST_RUN: begin
                if (valid_q && o_ready) begin
`ifdef KYBER_UNPACK_RANGE_CHECK_EN
                    if (word_oor_c) begin
                        err_d = 1'b1;
                    end
`endif
                    if (last_q) begin
                        state_d = ST_DONE;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        load = 1'b1;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // Register the next word so a handshake is followed by data without a bubble.
        if (load) begin
            valid_d = 1'b1;
            addr_d  = load_idx;
            last_d  = (load_idx == LAST_ADDR);
            data_d  = word_c;
        end
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            mode_q  <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
`ifdef KYBER_UNPACK_RANGE_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
`ifdef KYBER_UNPACK_RANGE_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    assign o_valid = valid_q;
    assign o_addr  = addr_q;
    assign o_data  = data_q;
    assign o_last  = last_q;
    assign o_busy  = busy_q;
    assign o_done  = done_q;
`ifdef KYBER_UNPACK_RANGE_CHECK_EN
    assign o_range_err = err_q;
`else
    assign o_range_err = 1'b0;
`endif

endmodule

// File: doc/kyber_polyvec_unpack.md
# kyber_polyvec_unpack

Parametrised unpacker that turns a byte-packed Kyber polynomial vector into 128-bit BRAM words of zero-extended 12-bit coefficients. It generalises the Kyber512-only encrypt/decrypt state unpack to any `KYBER_K` and adds output backpressure, a last-word marker and an optional coefficient range check. It sits between the AXI key registers and the polyvec BRAM that feeds the NTT/matrix-multiply datapath, and serves both encryption (public key) and decryption (secret key).

## Interface
Parameters:
- `KYBER_K`, 2: polynomials in the vector (2/3/4 for Kyber512/768/1024).
- `KYBER_N`, 256: coefficients per polynomial.
- `COEF_PER_WORD`, 8: coefficients per output word; must divide `KYBER_N` and be even.
- `SEED_BYTES`, 32: seed bytes at the low end of a packed public key.
- `IN_W`, 8*(384*KYBER_K+SEED_BYTES): packed input width.
- Derived: `WORDS` = `KYBER_K*KYBER_N/COEF_PER_WORD`; `ADDR_W` = clog2(`WORDS`); `DATA_W` = 16*`COEF_PER_WORD`.

Ports:
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `start`, in, 1: one-cycle request; sampled only in IDLE.
- `mode`, in, 1: 0 = public key (skip seed), 1 = secret key (no seed).
- `i_packed`, in, `IN_W`: packed bytes; held stable from `start` until `o_done`.
- `o_valid`, out, 1: output word valid.
- `o_ready`, in, 1: sink accepts the word.
- `o_addr`, out, `ADDR_W`: word address.
- `o_data`, out, `DATA_W`: coefficient word.
- `o_last`, out, 1: high with the word at address `WORDS-1`.
- `o_busy`, out, 1: high outside IDLE.
- `o_done`, out, 1: one-cycle completion pulse.
- `o_range_err`, out, 1: sticky out-of-range flag (see Configuration).

## Operation
- Region base bit: `mode`=0 gives 8*`SEED_BYTES`; `mode`=1 gives 0. `mode` is latched at `start`.
- Region byte x occupies `i_packed[base+8x+7 : base+8x]`.
- Coefficient pair i, with bytes b = 3i..3i+2:
  - r[2i] = b[3i] | (b[3i+1] & 0xF) << 8.
  - r[2i+1] = b[3i+1] >> 4 | b[3i+2] << 4.
- Word w, lane L (L = 0..`COEF_PER_WORD`-1) carries global coefficient c = w*`COEF_PER_WORD`+L.
  - `o_data[16L+11:16L]` = r[c]; `o_data[16L+15:16L+12]` = 0.
  - Polynomial boundaries are contiguous in c.
- FSM states: IDLE, RUN, DONE.
  - IDLE to RUN on `start`.
  - RUN to DONE on the handshake of the `o_last` word.
  - DONE to IDLE unconditionally after one cycle.
- Word index counter: cleared on `start`, incremented on each handshake (`o_valid & o_ready`). It never wraps inside a job.

## Timing
- Reset values: `o_valid`, `o_last`, `o_busy`, `o_done` and `o_range_err` are 0; `o_addr` and `o_data` are 0; state is IDLE.
- Latency: `start` in cycle t gives `o_valid`=1 with `o_addr`=0 in cycle t+1.
- Output register:
  - Each word is registered; `o_data`/`o_addr`/`o_last` are stable while `o_valid` is high and `o_ready` is low.
  - With `o_ready` tied high, one word is emitted per cycle, so throughput is `WORDS` cycles.
  - After a handshake on word n, word n+1 is presented the next cycle with no bubble.
- Last word: the handshake of address `WORDS-1` in cycle t gives `o_valid`=0 in t+1, `o_done`=1 in t+1, and IDLE in t+2.
- `start` while `o_busy` is ignored; it is neither queued nor restarts the job.
- Reset asserted mid-job discards the job on the next edge; all outputs return to reset values and no `o_done` is produced.

## Configuration
- `KYBER_UNPACK_RANGE_CHECK_EN` defined:
  - `o_range_err` is set when any coefficient of a handshaken word is >= 3329 (q).
  - It is cleared on accepted `start` and held through IDLE until the next `start`.
  - Data is passed through unmodified.
- Undefined: `o_range_err` is tied to 0 and the compare logic is absent.

## Structure
- Shared package `kyber_pkg`:
  - Constants `KYBER_Q`=3329, `KYBER_POLYBYTES`=384 and `COEF_BITS`=12.
  - The unpack FSM state enum.
- One sub-module `kyber_coef_pair_decode`: combinational, 3 bytes in, two 12-bit coefficients out. It is instantiated `COEF_PER_WORD/2` times.
- Byte selection uses an indexed part-select off (base + word index * 12*`COEF_PER_WORD`).

## Test plan
- All-zero `i_packed`, K=2, `o_ready`=1:
  - 64 words, addresses 0..63, all data 0.
  - `o_last` on address 63 only.
  - `o_done` one cycle after the last word.
- `mode`=1, region bytes 0x01,0x23,0x45 repeated: every lane pair is {0x0452, 0x0301}, so `o_data`[31:0]=0x04520301.
- `mode`=0, seed bytes 0xFF and region zero: all words 0, which proves the seed is skipped.
- Random backpressure (`o_ready` 50 %): the word sequence is identical to a golden C `poly_frombytes` model, and the data is stable while stalled.
- K=4 parameterisation: 128 words, `ADDR_W`=7, `start` pulsed mid-job is ignored, and `rst_n` low at word 40 returns to reset values with no `o_done`.
- With `KYBER_UNPACK_RANGE_CHECK_EN`:
  - Region bytes 0xFF,0xFF,0xFF give coefficient 0xFFF, so `o_range_err`=1 after the first handshake.
  - The next `start` clears it.
